// File: rtl/softmax_pkg.sv
// Shared widths, length-mode encodings and group-boundary helper for the softmax datapath.
package softmax_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned LANES  = 64;
  localparam int unsigned PTR_W  = 6;
  localparam int unsigned FLAT_W = LANES * DATA_W;
  localparam int unsigned MODE_W = 2;

  localparam logic [DATA_W-1:0] PAD_VAL_DEFAULT = 16'h8000;

  typedef enum logic [MODE_W-1:0] {
    MODE_1X64 = 2'd0,
    MODE_2X32 = 2'd1,
    MODE_4X16 = 2'd2,
    MODE_RSVD = 2'd3
  } len_mode_e;

  // Reserved encoding behaves as a single 64-lane group.
  function automatic len_mode_e norm_mode(input logic [MODE_W-1:0] mode);
    len_mode_e m;
    m = len_mode_e'(mode);
    if (m == MODE_RSVD) begin
      m = MODE_1X64;
    end
    return m;
  endfunction

  // First lane index of the group after the one holding ptr (64 = end of vector).
  function automatic logic [PTR_W:0] next_boundary(input logic [PTR_W-1:0] ptr,
                                                   input len_mode_e         mode);
    logic [PTR_W:0] b;
    case (mode)
      MODE_2X32: b = {1'b0, ptr[5], 5'b0_0000} + 7'd32;
      MODE_4X16: b = {1'b0, ptr[5:4], 4'b0000} + 7'd16;
      default:   b = 7'd64;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/vec_packer_64.sv
// Packs a stream of Q5.10 elements into 64-lane vectors, grouped as 1x64, 2x32 or 4x16,
// padding lanes skipped by i_last and emitting each completed vector with a one-cycle pulse.
module vec_packer_64
  import softmax_pkg::*;
#(
  parameter logic [15:0] PAD_VAL = PAD_VAL_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [1:0]    i_length_mode,
  input  logic [15:0]   i_data,
  input  logic          i_data_valid,
  input  logic          i_last,
  output logic          o_valid,
  output logic [1:0]    o_length_mode,
  output logic [63:0]   o_valid_mask,
  output logic [1023:0] o_in_flat,
  output logic          o_busy
);

  // Fill-side state
  logic [PTR_W-1:0]                 wr_ptr_q,    wr_ptr_d;
  logic [LANES-1:0]                 fill_mask_q, fill_mask_d;
  logic [LANES-1:0][DATA_W-1:0]     fill_q,      fill_d;
  len_mode_e                        mode_q,      mode_d;

  // Emitted-vector state
  logic                             valid_q,     valid_d;
  logic [MODE_W-1:0]                out_mode_q,  out_mode_d;
  logic [LANES-1:0]                 out_mask_q,  out_mask_d;
  logic [LANES-1:0][DATA_W-1:0]     out_flat_q,  out_flat_d;
  logic                             busy_q,      busy_d;

  // Per-element decode
  logic                             accept_c;
  logic                             start_c;
  len_mode_e                        eff_mode_c;
  logic [PTR_W:0]                   bound_c;
  logic [PTR_W:0]                   adv_c;
  logic                             complete_c;

  // Decode where the accepted element lands and whether it closes the vector.
  always_comb begin
    accept_c   = i_en & i_data_valid;
    start_c    = (wr_ptr_q == '0) && (fill_mask_q == '0);
    eff_mode_c = start_c ? norm_mode(i_length_mode) : mode_q;
    bound_c    = next_boundary(wr_ptr_q, eff_mode_c);
    adv_c      = i_last ? bound_c : ({1'b0, wr_ptr_q} + 7'd1);
    complete_c = accept_c && (adv_c == 7'(LANES));
  end

  // Next-state: write lane, advance pointer, hand off the buffer on completion.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_mask_d = fill_mask_q;
    fill_d      = fill_q;
    mode_d      = mode_q;
    valid_d     = 1'b0;
    out_mode_d  = out_mode_q;
    out_mask_d  = out_mask_q;
    out_flat_d  = out_flat_q;

    if (accept_c) begin
      mode_d                = eff_mode_c;
      fill_d[wr_ptr_q]      = i_data;
      fill_mask_d[wr_ptr_q] = 1'b1;
      if (complete_c) begin
        out_flat_d  = fill_d;
        out_mask_d  = fill_mask_d;
        out_mode_d  = eff_mode_c;
        valid_d     = 1'b1;
        wr_ptr_d    = '0;
        fill_mask_d = '0;
        fill_d      = {LANES{PAD_VAL}};
      end else begin
        wr_ptr_d = adv_c[PTR_W-1:0];
      end
    end

    busy_d = (wr_ptr_d != '0);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      fill_mask_q <= '0;
      fill_q      <= {LANES{PAD_VAL}};
      mode_q      <= MODE_1X64;
      valid_q     <= 1'b0;
      out_mode_q  <= '0;
      out_mask_q  <= '0;
      out_flat_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_mask_q <= fill_mask_d;
      fill_q      <= fill_d;
      mode_q      <= mode_d;
      valid_q     <= valid_d;
      out_mode_q  <= out_mode_d;
      out_mask_q  <= out_mask_d;
      out_flat_q  <= out_flat_d;
      busy_q      <= busy_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_length_mode = out_mode_q;
  assign o_valid_mask  = out_mask_q;
  assign o_in_flat     = out_flat_q;
  assign o_busy        = busy_q;

endmodule
